// File: rtl/canyon_input_ctrl.sv
// canyon_input_ctrl: player-input front end for the Canyon Bomber core.
//
// Decodes PS/2 key events and joystick bits into active-low fire lines, and turns each
// start request into a timed coin -> gap -> start sequence so the game sees a credit
// before the start press.
//
// Ports:
//   clk_sys             system clock
//   reset               asynchronous active-high reset
//   ps2_key[10:0]       [10] event toggle, [9] pressed, [8:0] scan code ([8] = extended)
//   joystick_0/1[15:0]  [4] fire, [5] start, other bits unused
//   coin1_n/coin2_n     active-low coin lines
//   start1_n/start2_n   active-low start lines
//   fire1_n/fire2_n     active-low fire lines
//   seq_busy            high whenever the sequencer is not idle
module canyon_input_ctrl #(
   parameter int unsigned TICK_DIV = 48000,
   parameter int unsigned COIN_MS  = 50,
   parameter int unsigned GAP_MS   = 100,
   parameter int unsigned START_MS = 50
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   output logic        coin1_n,
   output logic        coin2_n,
   output logic        start1_n,
   output logic        start2_n,
   output logic        fire1_n,
   output logic        fire2_n,
   output logic        seq_busy
);

   localparam int unsigned CoinCyc  = COIN_MS * TICK_DIV;
   localparam int unsigned GapCyc   = GAP_MS * TICK_DIV;
   localparam int unsigned StartCyc = START_MS * TICK_DIV;
   localparam int unsigned MaxCyc0  = (CoinCyc > GapCyc) ? CoinCyc : GapCyc;
   localparam int unsigned MaxCyc   = (MaxCyc0 > StartCyc) ? MaxCyc0 : StartCyc;
   // Counter only ever holds product-1, so clog2(max product) bits suffice.
   localparam int unsigned CntW     = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

   localparam logic [CntW-1:0] CoinLoad  = CntW'(CoinCyc - 1);
   localparam logic [CntW-1:0] GapLoad   = CntW'(GapCyc - 1);
   localparam logic [CntW-1:0] StartLoad = CntW'(StartCyc - 1);

   typedef enum logic [2:0] {StIdle, StCoin, StGap, StStart, StRelease} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            player_q, player_d;  // 0 = player 1, 1 = player 2
   logic            primed_q, primed_d;
   logic            tog_q, tog_d;
   logic            kb_fire_q, kb_fire_d;
   logic            kb_start1_q, kb_start1_d;
   logic            kb_start2_q, kb_start2_d;
   logic            req1_q, req2_q;
   logic            coin1_n_q, coin1_n_d, coin2_n_q, coin2_n_d;
   logic            start1_n_q, start1_n_d, start2_n_q, start2_n_d;
   logic            fire1_n_q, fire1_n_d, fire2_n_q, fire2_n_d;
   logic            busy_q, busy_d;

   logic key_evt, req1, req2, rise1, rise2, req_sel;

   logic unused_joy;
   assign unused_joy = ^{joystick_0[15:6], joystick_0[3:0], joystick_1[15:6], joystick_1[3:0]};

   // Key decode. The first cycle after reset only captures the toggle (primed_q = 0).
   assign key_evt = primed_q & (ps2_key[10] ^ tog_q);

   always_comb begin
      primed_d    = 1'b1;
      tog_d       = ps2_key[10];
      kb_fire_d   = kb_fire_q;
      kb_start1_d = kb_start1_q;
      kb_start2_d = kb_start2_q;
      if (key_evt) begin
         case (ps2_key[8:0])
            9'h029, 9'h014: kb_fire_d   = ps2_key[9];
            9'h005:         kb_start1_d = ps2_key[9];
            9'h006:         kb_start2_d = ps2_key[9];
            default: ;
         endcase
      end
   end

   assign req1    = kb_start1_q | joystick_0[5];
   assign req2    = kb_start2_q | joystick_1[5];
   assign rise1   = req1 & ~req1_q;
   assign rise2   = req2 & ~req2_q;
   assign req_sel = player_q ? req2 : req1;

   // Sequencer next state. Edges seen outside idle are dropped, not queued.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      player_d = player_q;
      case (state_q)
         StIdle: begin
            if (rise1) begin
               player_d = 1'b0;
               state_d  = StCoin;
               cnt_d    = CoinLoad;
            end else if (rise2) begin
               player_d = 1'b1;
               state_d  = StCoin;
               cnt_d    = CoinLoad;
            end
         end
         StCoin: begin
            if (cnt_q == '0) begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StStart;
               cnt_d   = StartLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StStart: begin
            if (cnt_q == '0) begin
               state_d = StRelease;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRelease: begin
            if (!req_sel) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from next state so a joystick edge drops coin on the same edge.
   always_comb begin
      coin1_n_d  = ~((state_d == StCoin) & ~player_d);
      coin2_n_d  = ~((state_d == StCoin) & player_d);
      start1_n_d = ~((state_d == StStart) & ~player_d);
      start2_n_d = ~((state_d == StStart) & player_d);
      busy_d     = (state_d != StIdle);
      fire1_n_d  = ~(kb_fire_q | joystick_0[4]);
      fire2_n_d  = ~(kb_fire_q | joystick_1[4]);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         player_q    <= 1'b0;
         primed_q    <= 1'b0;
         tog_q       <= 1'b0;
         kb_fire_q   <= 1'b0;
         kb_start1_q <= 1'b0;
         kb_start2_q <= 1'b0;
         req1_q      <= 1'b0;
         req2_q      <= 1'b0;
         coin1_n_q   <= 1'b1;
         coin2_n_q   <= 1'b1;
         start1_n_q  <= 1'b1;
         start2_n_q  <= 1'b1;
         fire1_n_q   <= 1'b1;
         fire2_n_q   <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         player_q    <= player_d;
         primed_q    <= primed_d;
         tog_q       <= tog_d;
         kb_fire_q   <= kb_fire_d;
         kb_start1_q <= kb_start1_d;
         kb_start2_q <= kb_start2_d;
         req1_q      <= req1;
         req2_q      <= req2;
         coin1_n_q   <= coin1_n_d;
         coin2_n_q   <= coin2_n_d;
         start1_n_q  <= start1_n_d;
         start2_n_q  <= start2_n_d;
         fire1_n_q   <= fire1_n_d;
         fire2_n_q   <= fire2_n_d;
         busy_q      <= busy_d;
      end
   end

   assign coin1_n  = coin1_n_q;
   assign coin2_n  = coin2_n_q;
   assign start1_n = start1_n_q;
   assign start2_n = start2_n_q;
   assign fire1_n  = fire1_n_q;
   assign fire2_n  = fire2_n_q;
   assign seq_busy = busy_q;

endmodule

// File: tb/tb_canyon_input_ctrl.sv
// Bench for canyon_input_ctrl: directed scenarios followed by random stimulus, all checked
// every cycle against a timeline model (phases derived from the acceptance cycle).
module tb_canyon_input_ctrl;

   localparam int unsigned TickDiv = 4;
   localparam int unsigned CoinMs  = 2;
   localparam int unsigned GapMs   = 3;
   localparam int unsigned StartMs = 2;
   localparam int C = CoinMs * TickDiv;
   localparam int G = GapMs * TickDiv;
   localparam int S = StartMs * TickDiv;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0, joystick_1;
   logic        coin1_n, coin2_n, start1_n, start2_n, fire1_n, fire2_n, seq_busy;

   canyon_input_ctrl #(
      .TICK_DIV(TickDiv),
      .COIN_MS (CoinMs),
      .GAP_MS  (GapMs),
      .START_MS(StartMs)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_key   (ps2_key),
      .joystick_0(joystick_0),
      .joystick_1(joystick_1),
      .coin1_n   (coin1_n),
      .coin2_n   (coin2_n),
      .start1_n  (start1_n),
      .start2_n  (start2_n),
      .fire1_n   (fire1_n),
      .fire2_n   (fire2_n),
      .seq_busy  (seq_busy)
   );

   always #5 clk_sys = ~clk_sys;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Model state: key flags, previous requests, and the active sequence as (start cycle, player).
   bit m_primed, m_tog, m_kf, m_ks1, m_ks2, m_rq1, m_rq2, m_busy, m_p2;
   int m_t0;
   bit e_c1, e_c2, e_s1, e_s2, e_f1, e_f2, e_busy;

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("coin1_n", coin1_n, e_c1);
      chk("coin2_n", coin2_n, e_c2);
      chk("start1_n", start1_n, e_s1);
      chk("start2_n", start2_n, e_s2);
      chk("fire1_n", fire1_n, e_f1);
      chk("fire2_n", fire2_n, e_f2);
      chk("seq_busy", seq_busy, e_busy);
   endtask

   task automatic model_reset();
      m_primed = 0; m_tog = 0; m_kf = 0; m_ks1 = 0; m_ks2 = 0;
      m_rq1 = 0; m_rq2 = 0; m_busy = 0; m_p2 = 0; m_t0 = 0;
      e_c1 = 1; e_c2 = 1; e_s1 = 1; e_s2 = 1; e_f1 = 1; e_f2 = 1; e_busy = 0;
   endtask

   task automatic model_edge();
      bit r1, r2, f1, f2, rp;
      int d;
      cyc++;
      r1 = m_ks1 | joystick_0[5];
      r2 = m_ks2 | joystick_1[5];
      f1 = m_kf | joystick_0[4];
      f2 = m_kf | joystick_1[4];
      if (m_busy) begin
         rp = m_p2 ? r2 : r1;
         if ((cyc - m_t0) > C + G + S && !rp) m_busy = 0;
      end else if (r1 && !m_rq1) begin
         m_busy = 1; m_t0 = cyc; m_p2 = 0;
      end else if (r2 && !m_rq2) begin
         m_busy = 1; m_t0 = cyc; m_p2 = 1;
      end
      m_rq1 = r1;
      m_rq2 = r2;
      if (!m_primed) begin
         m_primed = 1;
         m_tog    = ps2_key[10];
      end else if (ps2_key[10] != m_tog) begin
         m_tog = ps2_key[10];
         if (ps2_key[8:0] == 9'h029 || ps2_key[8:0] == 9'h014) m_kf = ps2_key[9];
         if (ps2_key[8:0] == 9'h005) m_ks1 = ps2_key[9];
         if (ps2_key[8:0] == 9'h006) m_ks2 = ps2_key[9];
      end
      d      = cyc - m_t0;
      e_f1   = !f1;
      e_f2   = !f2;
      e_busy = m_busy;
      e_c1   = !(m_busy && !m_p2 && d < C);
      e_c2   = !(m_busy && m_p2 && d < C);
      e_s1   = !(m_busy && !m_p2 && d >= C + G && d < C + G + S);
      e_s2   = !(m_busy && m_p2 && d >= C + G && d < C + G + S);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         model_edge();
         #1;
         chk_all();
      end
   endtask

   task automatic key(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   // Asynchronous reset mid-cycle; outputs must go high before any clock edge.
   task automatic do_reset(input logic [10:0] key_during);
      reset = 1'b1;
      #1;
      ps2_key = key_during;
      model_reset();
      chk_all();
      @(posedge clk_sys);
      #1;
      chk_all();
      @(negedge clk_sys);
      reset = 1'b0;
   endtask

   initial begin
      logic [8:0] codes [7];
      codes = '{9'h029, 9'h014, 9'h005, 9'h006, 9'h114, 9'h105, 9'h0ff};
      reset      = 1'b1;
      ps2_key    = '0;
      joystick_0 = '0;
      joystick_1 = '0;
      model_reset();
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      reset = 1'b0;
      chk_all();

      // Joystick 1 start from edge 10, held well past the sequence.
      step(9);
      joystick_0[5] = 1'b1;
      step(45);
      joystick_0[5] = 1'b0;
      step(3);

      // Keyboard F2, release event during START.
      key(9'h006, 1'b1);
      step(25);
      key(9'h006, 1'b0);
      step(15);

      // Simultaneous starts, then a fresh player 2 edge.
      joystick_0[5] = 1'b1;
      joystick_1[5] = 1'b1;
      step(35);
      joystick_0[5] = 1'b0;
      step(3);
      joystick_1[5] = 1'b0;
      step(2);
      joystick_1[5] = 1'b1;
      step(35);
      joystick_1[5] = 1'b0;
      step(3);

      // Fire paths and the extended-code non-match.
      key(9'h029, 1'b1);
      step(3);
      key(9'h029, 1'b0);
      step(3);
      joystick_1[4] = 1'b1;
      step(2);
      joystick_1[4] = 1'b0;
      step(2);
      key(9'h114, 1'b1);
      step(2);
      key(9'h114, 1'b0);
      step(2);

      // Reset during GAP with the toggle bit high and the joystick start held.
      joystick_0[5] = 1'b1;
      step(12);
      do_reset({1'b1, 1'b1, 9'h029});
      step(5);
      joystick_0[5] = 1'b0;
      step(30);

      // Random stimulus.
      for (int n = 0; n < 3000; n++) begin
         joystick_0[15:6] = 10'($urandom);
         joystick_0[3:0]  = 4'($urandom);
         joystick_1[15:6] = 10'($urandom);
         joystick_1[3:0]  = 4'($urandom);
         if ($urandom_range(0, 39) == 0) joystick_0[5] = ~joystick_0[5];
         if ($urandom_range(0, 39) == 0) joystick_1[5] = ~joystick_1[5];
         if ($urandom_range(0, 9) == 0) joystick_0[4] = ~joystick_0[4];
         if ($urandom_range(0, 9) == 0) joystick_1[4] = ~joystick_1[4];
         if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 7) == 0) key(9'($urandom), 1'($urandom));
            else key(codes[$urandom_range(0, 6)], 1'($urandom));
         end
         if ($urandom_range(0, 599) == 0) do_reset(ps2_key);
         step(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
